game_beat_seq: RTL and testbench
================================

Name: game_beat_seq

Overview:
- Beat sequencer that sits directly upstream of the game note-frequency lookup.
- Produces the two-digit BCD beat index `num1`:`num0` at a programmable tempo, plus a per-beat articulation mute and status strobes.
- Supports play/pause, stop, end-of-song stop or loop.
- The lookup converts the index into left/right note dividers; the tone generator gates its output with `mute`.

Parameters:
- TEMPO_DIV, 25_000_000, clock cycles per beat (0.25 s at 100 MHz); must be ≥ 2.
- CNT_W, 25, width of the beat-cycle counter; must satisfy 2^CNT_W ≥ TEMPO_DIV.
- GAP_CYC, 2_500_000, trailing cycles of each beat with `mute` forced high; must be < TEMPO_DIV.
- LAST_TENS, 3, BCD tens digit of the final beat.
- LAST_ONES, 1, BCD ones digit of the final beat (final beat = 31).
- LOOP, 0, 1 = wrap to beat 00 after the final beat; 0 = stop in DONE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- play  in  1  single-cycle pulse (already debounced/one-pulsed): start / pause / resume / restart
- stop  in  1  single-cycle pulse: abort and return to beat 00
- num0  out  4  BCD ones digit of current beat, 0–9
- num1  out  4  BCD tens digit of current beat, 0–9
- mute  out  1  1 = downstream tone must be silent
- playing  out  1  1 while state is PLAY
- beat_tick  out  1  one-cycle pulse in the cycle the index changes while playing
- song_done  out  1  one-cycle pulse when the final beat completes

Behaviour:
- All state is registered on posedge `clk`.
- On `rst`: state IDLE, count 0, num1 = 0, num0 = 0, beat_tick 0, song_done 0. Combinationally this gives playing 0 and mute 1. `rst` overrides all inputs.
- FSM states: IDLE, PLAY, PAUSE, DONE.
  - IDLE: index held at 00, count 0. A `play` pulse moves to PLAY with count 0 and index 00.
  - PLAY: count increments each cycle.
    - When count == TEMPO_DIV-1, count wraps to 0 next cycle, the index advances, and beat_tick is 1 in that next cycle.
    - A `play` pulse moves to PAUSE.
  - PAUSE: count and index are frozen. A `play` pulse returns to PLAY and resumes from the frozen count.
  - DONE: index held at the final beat. A `play` pulse restarts PLAY at index 00 with count 0.
- `stop` in any state: IDLE next cycle, index 00, count 0. If `stop` and `play` arrive in the same cycle, `stop` wins.
- BCD advance: if num0 == 9, num0 becomes 0 and num1 increments; otherwise num0 increments. Values A–F never appear on either digit.
- End of song: applies when count == TEMPO_DIV-1 and index == LAST_TENS:LAST_ONES.
  - LOOP = 1: index becomes 00, stay in PLAY, beat_tick and song_done both pulse.
  - LOOP = 0: go to DONE, index stays at the final beat, song_done pulses, beat_tick stays 0.
- Index beyond the last beat (only possible after a parameter change): the tens digit wraps 9→0 and no error is flagged.
- `mute` = (state != PLAY) OR (count ≥ TEMPO_DIV-GAP_CYC). It is a combinational decode of registered state and count. Repeated identical notes therefore re-articulate.
- `playing` = (state == PLAY).
- Latency: index and status outputs change one cycle after the triggering count value or input pulse. The index is stable for the whole beat.

Decomposition:
- Shared package `game_pkg` holds:
  - the state enum (IDLE/PLAY/PAUSE/DONE, 2-bit encoding);
  - the BCD digit width constant (4);
  - the default tempo and gap constants, so the tone generator and display agree.
- One natural sub-module: `bcd_cnt2`, a two-digit BCD counter with `clr`, `inc`, `at_last` compare, and synchronous active-high reset. The top module keeps the FSM and the tempo counter.

Test Plan (TEMPO_DIV=4, CNT_W=3, GAP_CYC=1, LAST=31, LOOP=0 unless stated):
- Reset: hold `rst` 3 cycles with `play` asserted → num1:num0 = 00, mute 1, playing 0, beat_tick 0, song_done 0 throughout and after release.
- BCD carry: `play` pulse, run 40 cycles → index goes 00,01,…,09,10. Each value is held exactly 4 cycles, 0A never appears, beat_tick fires 10 times, and mute is 1 only on each beat's 4th cycle.
- Pause: pause when index = 05 and count = 2, wait 20 cycles (index 05, mute 1, count frozen), then `play` → index 06 exactly 2 cycles after resume.
- End of song, LOOP=0: run to beat 31 → after its 4th cycle song_done pulses once, state DONE, index stays 31, mute 1. A further `play` restarts at 00.
- End of song, LOOP=1: at the end of beat 31 → index 00, beat_tick and song_done pulse in the same cycle, playing stays 1.
- Stop priority: `stop` and `play` in the same cycle while at beat 17 → next cycle IDLE, index 00, mute 1, playing 0, no beat_tick.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and defaults for the game audio path: beat sequencer state,
// BCD digit width and the default tempo/gap so tone generator and display agree.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_W             = 4;
  localparam int TEMPO_DIV_DEFAULT = 25_000_000;
  localparam int CNT_W_DEFAULT     = 25;
  localparam int GAP_CYC_DEFAULT   = 2_500_000;

  function automatic logic [BCD_W-1:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_W'(9)) ? '0 : d + BCD_W'(1);
  endfunction

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD counter (tens:ones) with clear, increment and a compare
// against a fixed last value; wraps 99 -> 00.
module bcd_cnt2
  import game_pkg::*;
#(
  parameter int LAST_TENS = 3,
  parameter int LAST_ONES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] num0,
  output logic [BCD_W-1:0] num1,
  output logic             at_last
);

  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] r_tens;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (inc) begin
      r_ones <= bcd_digit_inc(r_ones);
      if (r_ones == BCD_W'(9)) begin
        r_tens <= bcd_digit_inc(r_tens);
      end
    end
  end

  assign num0    = r_ones;
  assign num1    = r_tens;
  assign at_last = (r_tens == BCD_W'(LAST_TENS)) && (r_ones == BCD_W'(LAST_ONES));

endmodule

// File: rtl/game_beat_seq.sv
// Beat sequencer: play/pause/stop FSM plus tempo counter driving a two-digit
// BCD beat index, an articulation mute and per-beat / end-of-song strobes.
module game_beat_seq
  import game_pkg::*;
#(
  parameter int TEMPO_DIV = TEMPO_DIV_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int GAP_CYC   = GAP_CYC_DEFAULT,
  parameter int LAST_TENS = 3,
  parameter int LAST_ONES = 1,
  parameter int LOOP      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic             stop,
  output logic [BCD_W-1:0] num0,
  output logic [BCD_W-1:0] num1,
  output logic             mute,
  output logic             playing,
  output logic             beat_tick,
  output logic             song_done
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST  = CNT_W'(TEMPO_DIV - 1);
  localparam logic [CNT_W-1:0] LP_GAP_START = CNT_W'(TEMPO_DIV - GAP_CYC);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_beat_tick;
  logic             r_song_done;
  logic             w_tick;
  logic             w_done;
  logic             w_clr;
  logic             w_inc;
  logic             w_at_last;
  logic             w_beat_end;

  bcd_cnt2 #(
    .LAST_TENS (LAST_TENS),
    .LAST_ONES (LAST_ONES)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .inc     (w_inc),
    .num0    (num0),
    .num1    (num1),
    .at_last (w_at_last)
  );

  assign w_beat_end = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_beat_tick <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_beat_tick <= w_tick;
      r_song_done <= w_done;
    end
  end

  // stop beats every other input; a play pulse in PLAY freezes the count
  // exactly where it is so resume continues the same beat.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_clr        = 1'b0;
    w_inc        = 1'b0;
    w_tick       = 1'b0;
    w_done       = 1'b0;
    if (stop) begin
      w_next_state = IDLE;
      w_next_cnt   = '0;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_cnt = '0;
          w_clr      = 1'b1;
          if (play) begin
            w_next_state = PLAY;
          end
        end
        PLAY: begin
          if (play) begin
            w_next_state = PAUSE;
          end else if (w_beat_end) begin
            w_next_cnt = '0;
            if (w_at_last) begin
              w_done = 1'b1;
              if (LOOP != 0) begin
                w_clr  = 1'b1;
                w_tick = 1'b1;
              end else begin
                w_next_state = DONE;
              end
            end else begin
              w_inc  = 1'b1;
              w_tick = 1'b1;
            end
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        PAUSE: begin
          if (play) begin
            w_next_state = PLAY;
          end
        end
        DONE: begin
          if (play) begin
            w_next_state = PLAY;
            w_next_cnt   = '0;
            w_clr        = 1'b1;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
          w_clr        = 1'b1;
        end
      endcase
    end
  end

  assign playing   = (r_state == PLAY);
  assign mute      = (r_state != PLAY) || (r_cnt >= LP_GAP_START);
  assign beat_tick = r_beat_tick;
  assign song_done = r_song_done;

endmodule

// File: tb/tb_game_beat_seq.sv
// Directed bench for game_beat_seq at TEMPO_DIV=4, GAP_CYC=1, last beat 31,
// with one non-looping and one looping instance.
module tb_game_beat_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       play = 1'b0, stop = 1'b0;
  logic       play2 = 1'b0, stop2 = 1'b0;
  logic [3:0] num0, num1, num0b, num1b;
  logic       mute, playing, beat_tick, song_done;
  logic       muteB, playingB, beatTickB, songDoneB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_beat_seq #(
    .TEMPO_DIV(4), .CNT_W(3), .GAP_CYC(1), .LAST_TENS(3), .LAST_ONES(1), .LOOP(0)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop),
    .num0(num0), .num1(num1), .mute(mute), .playing(playing),
    .beat_tick(beat_tick), .song_done(song_done)
  );

  game_beat_seq #(
    .TEMPO_DIV(4), .CNT_W(3), .GAP_CYC(1), .LAST_TENS(3), .LAST_ONES(1), .LOOP(1)
  ) dutLoop (
    .clk(clk), .rst(rst), .play(play2), .stop(stop2),
    .num0(num0b), .num1(num1b), .mute(muteB), .playing(playingB),
    .beat_tick(beatTickB), .song_done(songDoneB)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulsePlay();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // vector = {num1, num0, mute, playing, beat_tick, song_done}
  task automatic test_reset();
    logic [11:0] got;
    rst = 1'b1; play = 1'b1; play2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {num1, num0, mute, playing, beat_tick, song_done};
      total++;
      if (got !== 12'h008) begin
        $display("[TB] FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, 12'h008);
        bad++;
      end
    end
    rst = 1'b0; play = 1'b0; play2 = 1'b0;
    step();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h008) begin
      $display("[TB] FAIL reset_release got=%h exp=%h", got, 12'h008);
      bad++;
    end
    got = {num1b, num0b, muteB, playingB, beatTickB, songDoneB};
    total++;
    if (got !== 12'h008) begin
      $display("[TB] FAIL reset_loop_inst got=%h exp=%h", got, 12'h008);
      bad++;
    end
  endtask

  task automatic test_bcd_carry();
    int          ticks = 0;
    int          idx;
    logic [11:0] got, exp;
    pulsePlay();
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step();
      idx = k / 4;
      exp = {4'(idx / 10), 4'(idx % 10), (k % 4) == 3, 1'b1, (k % 4 == 0) && (k > 0), 1'b0};
      got = {num1, num0, mute, playing, beat_tick, song_done};
      ticks += int'(beat_tick);
      total++;
      if (got !== exp) begin
        $display("[TB] FAIL bcd_carry k=%0d got=%h exp=%h", k, got, exp);
        bad++;
      end
    end
    total++;
    if (ticks !== 10) begin
      $display("[TB] FAIL bcd_tick_count got=%0d exp=10", ticks);
      bad++;
    end
    pulseStop();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h008) begin
      $display("[TB] FAIL stop_after_carry got=%h exp=%h", got, 12'h008);
      bad++;
    end
  endtask

  task automatic test_pause();
    logic [11:0] got;
    pulsePlay();
    for (int i = 0; i < 22; i++) step();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h054) begin
      $display("[TB] FAIL pause_entry got=%h exp=%h", got, 12'h054);
      bad++;
    end
    pulsePlay();
    for (int i = 0; i < 20; i++) begin
      got = {num1, num0, mute, playing, beat_tick, song_done};
      total++;
      if (got !== 12'h058) begin
        $display("[TB] FAIL pause_hold cyc=%0d got=%h exp=%h", i, got, 12'h058);
        bad++;
      end
      step();
    end
    pulsePlay();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h054) begin
      $display("[TB] FAIL resume_c0 got=%h exp=%h", got, 12'h054);
      bad++;
    end
    step();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h05C) begin
      $display("[TB] FAIL resume_c1 got=%h exp=%h", got, 12'h05C);
      bad++;
    end
    step();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h066) begin
      $display("[TB] FAIL resume_c2 got=%h exp=%h", got, 12'h066);
      bad++;
    end
    pulseStop();
  endtask

  task automatic test_end_song();
    int          dones = 0;
    int          ticks = 0;
    logic [11:0] got;
    pulsePlay();
    for (int k = 1; k <= 129; k++) begin
      step();
      dones += int'(song_done);
      ticks += int'(beat_tick);
      got = {num1, num0, mute, playing, beat_tick, song_done};
      if (k == 127) begin
        total++;
        if (got !== 12'h31C) begin
          $display("[TB] FAIL end_last_cycle got=%h exp=%h", got, 12'h31C);
          bad++;
        end
      end else if (k == 128) begin
        total++;
        if (got !== 12'h319) begin
          $display("[TB] FAIL end_done_pulse got=%h exp=%h", got, 12'h319);
          bad++;
        end
      end else if (k == 129) begin
        total++;
        if (got !== 12'h318) begin
          $display("[TB] FAIL end_done_hold got=%h exp=%h", got, 12'h318);
          bad++;
        end
      end
    end
    total++;
    if (dones !== 1 || ticks !== 31) begin
      $display("[TB] FAIL end_pulse_counts done=%0d tick=%0d exp done=1 tick=31", dones, ticks);
      bad++;
    end
    pulsePlay();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h004) begin
      $display("[TB] FAIL restart_from_done got=%h exp=%h", got, 12'h004);
      bad++;
    end
    pulseStop();
  endtask

  task automatic test_loop();
    logic [11:0] got;
    play2 = 1'b1;
    step();
    play2 = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      step();
      got = {num1b, num0b, muteB, playingB, beatTickB, songDoneB};
      if (k == 127) begin
        total++;
        if (got !== 12'h31C) begin
          $display("[TB] FAIL loop_last_cycle got=%h exp=%h", got, 12'h31C);
          bad++;
        end
      end else if (k == 128) begin
        total++;
        if (got !== 12'h007) begin
          $display("[TB] FAIL loop_wrap got=%h exp=%h", got, 12'h007);
          bad++;
        end
      end
    end
    step();
    got = {num1b, num0b, muteB, playingB, beatTickB, songDoneB};
    total++;
    if (got !== 12'h004) begin
      $display("[TB] FAIL loop_after_wrap got=%h exp=%h", got, 12'h004);
      bad++;
    end
    stop2 = 1'b1;
    step();
    stop2 = 1'b0;
  endtask

  task automatic test_stop_priority();
    logic [11:0] got;
    pulsePlay();
    for (int i = 0; i < 69; i++) step();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h174) begin
      $display("[TB] FAIL stop_pre_beat17 got=%h exp=%h", got, 12'h174);
      bad++;
    end
    stop = 1'b1; play = 1'b1;
    step();
    stop = 1'b0; play = 1'b0;
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h008) begin
      $display("[TB] FAIL stop_wins got=%h exp=%h", got, 12'h008);
      bad++;
    end
    step();
    got = {num1, num0, mute, playing, beat_tick, song_done};
    total++;
    if (got !== 12'h008) begin
      $display("[TB] FAIL stop_stays_idle got=%h exp=%h", got, 12'h008);
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_bcd_carry();
    test_pause();
    test_end_song();
    test_loop();
    test_stop_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
